// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and its neighbours
// (data memory, EX_MEM register).
package dmem_port_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 7;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_CNT_W  = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of lane request, memory port and status signals around the arbiter.
// slave: the arbiter's view; master: the pipeline/memory side.
interface dmem_port_arbiter_if
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned CNT_W  = DMEM_CNT_W
);
  logic              MEM_RD1;
  logic              MEM_WR1;
  logic              w_h1;
  logic [ADDR_W-1:0] DIR1;
  logic [DATA_W-1:0] DI1;
  logic              MEM_RD2;
  logic              MEM_WR2;
  logic              w_h2;
  logic [ADDR_W-1:0] DIR2;
  logic [DATA_W-1:0] DI2;
  logic [DATA_W-1:0] DO_mem;
  logic              MEM_RD;
  logic              MEM_WR;
  logic              w_h;
  logic [ADDR_W-1:0] DIR;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO1;
  logic [DATA_W-1:0] DO2;
  logic              stall;
  logic              busy;
  logic [CNT_W-1:0]  conf_cnt;

  modport slave (
    input  MEM_RD1, MEM_WR1, w_h1, DIR1, DI1,
    input  MEM_RD2, MEM_WR2, w_h2, DIR2, DI2,
    input  DO_mem,
    output MEM_RD, MEM_WR, w_h, DIR, DI,
    output DO1, DO2, stall, busy, conf_cnt
  );

  modport master (
    output MEM_RD1, MEM_WR1, w_h1, DIR1, DI1,
    output MEM_RD2, MEM_WR2, w_h2, DIR2, DI2,
    output DO_mem,
    input  MEM_RD, MEM_WR, w_h, DIR, DI,
    input  DO1, DO2, stall, busy, conf_cnt
  );

endinterface

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] r_count;

  // Count up on inc, hold once every bit is set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {width{1'b1}})) begin
      r_count <= r_count + width'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-ported data memory between the two issue lanes.
// A same-cycle conflict serves lane 1, stalls one cycle, then serves lane 2.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned CNT_W  = DMEM_CNT_W
) (
  input  logic                reloj,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
);

  arb_state_e        r_state;
  logic [DATA_W-1:0] r_hold1;

  logic              w_req1;
  logic              w_req2;
  logic              w_wr1;
  logic              w_rd1;
  logic              w_wr2;
  logic              w_rd2;
  logic              w_conflict;
  logic              w_sel2;
  logic [ADDR_W-1:0] w_dir;
  logic [CNT_W-1:0]  w_cnt;

  // A lane asserting both RD and WR is a write.
  assign w_wr1 = bus.MEM_WR1;
  assign w_rd1 = bus.MEM_RD1 & ~bus.MEM_WR1;
  assign w_wr2 = bus.MEM_WR2;
  assign w_rd2 = bus.MEM_RD2 & ~bus.MEM_WR2;
  assign w_req1 = w_rd1 | w_wr1;
  assign w_req2 = w_rd2 | w_wr2;

  assign w_conflict = (r_state == IDLE) & w_req1 & w_req2;
  // Lane 2 owns the port in SECOND, or in IDLE when it is the only requester.
  assign w_sel2 = (r_state == SECOND) | (~w_req1 & w_req2);

  // FSM and lane 1 read-data capture for the conflict cycle.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_hold1 <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_conflict) begin
            r_hold1 <= w_wr1 ? '0 : bus.DO_mem;
            r_state <= SECOND;
          end
        end
        SECOND: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Port mux, read-data steering and stall; everything forced to 0 in reset.
  always_comb begin
    bus.MEM_RD = 1'b0;
    bus.MEM_WR = 1'b0;
    bus.w_h    = 1'b0;
    w_dir      = '0;
    bus.DI     = '0;
    bus.DO1    = '0;
    bus.DO2    = '0;
    bus.stall  = 1'b0;
    bus.busy   = 1'b0;
    if (!reset) begin
      if (w_sel2) begin
        bus.MEM_RD = w_rd2;
        bus.MEM_WR = w_wr2;
        bus.w_h    = bus.w_h2;
        w_dir      = bus.DIR2;
        bus.DI     = bus.DI2;
      end else begin
        bus.MEM_RD = w_rd1;
        bus.MEM_WR = w_wr1;
        bus.w_h    = bus.w_h1;
        w_dir      = bus.DIR1;
        bus.DI     = bus.DI1;
      end
      bus.stall = w_conflict;
      bus.busy  = (r_state == SECOND);
      if (r_state == SECOND) begin
        bus.DO1 = r_hold1;
        bus.DO2 = bus.DO_mem;
      end else if (w_req1 && !w_req2) begin
        bus.DO1 = bus.DO_mem;
      end else if (w_req2 && !w_req1) begin
        bus.DO2 = bus.DO_mem;
      end
    end
  end

  assign bus.DIR      = w_dir;
  assign bus.conf_cnt = w_cnt;

  sat_counter #(
    .width (CNT_W)
  ) u_conf_cnt (
    .clock (reloj),
    .reset (reset),
    .inc   (w_conflict),
    .count (w_cnt)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-addressed memory model.
// The driver queues the expected port/status values for each cycle; the
// monitor pops and compares them on the falling edge.
module tb_dmem_port_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          wh;
    logic [AW-1:0] dir;
    logic [DW-1:0] di;
  } lane_t;

  typedef struct packed {
    logic          stall;
    logic          busy;
    logic          rd;
    logic          wr;
    logic          wh;
    logic [AW-1:0] dir;
    logic [DW-1:0] di;
    logic [DW-1:0] do1;
    logic [DW-1:0] do2;
    logic [CW-1:0] cnt;
  } exp_t;

  logic reloj = 1'b0;
  logic reset = 1'b1;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) u_if ();

  dmem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) u_dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 reloj = ~reloj;

  // Memory model: little-endian bytes, combinational read, write on rising edge.
  logic [7:0] mem [128];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hDEADBEEF;
    {mem[8'h07], mem[8'h06], mem[8'h05], mem[8'h04]} = 32'h0000000A;
    {mem[8'h0B], mem[8'h0A], mem[8'h09], mem[8'h08]} = 32'h0000000B;
    {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} = 32'h11111111;
    forever begin
      @(posedge reloj);
      if (u_if.MEM_WR) begin
        mem[u_if.DIR]         <= u_if.DI[7:0];
        mem[u_if.DIR + 7'd1]  <= u_if.DI[15:8];
        if (u_if.w_h) begin
          mem[u_if.DIR + 7'd2] <= u_if.DI[23:16];
          mem[u_if.DIR + 7'd3] <= u_if.DI[31:24];
        end
      end
    end
  end

  logic [DW-1:0] rd_word;
  always_comb begin
    rd_word = {mem[u_if.DIR + 7'd3], mem[u_if.DIR + 7'd2],
               mem[u_if.DIR + 7'd1], mem[u_if.DIR]};
    u_if.DO_mem = u_if.w_h ? rd_word : {16'h0000, rd_word[15:0]};
  end

  // Scoreboard.
  exp_t  exp_q  [$];
  bit    care_q [$];
  string name_q [$];
  int    checks   = 0;
  int    failures = 0;
  int    pushed   = 0;
  int    popped   = 0;

  function automatic lane_t ln_none();
    return '0;
  endfunction

  function automatic lane_t ln_rd(input logic [AW-1:0] a, input logic wh);
    lane_t l = '0;
    l.rd = 1'b1; l.wh = wh; l.dir = a;
    return l;
  endfunction

  function automatic lane_t ln_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    lane_t l = '0;
    l.wr = 1'b1; l.wh = 1'b1; l.dir = a; l.di = d;
    return l;
  endfunction

  function automatic exp_t ex(input logic st, input logic bz, input logic rd, input logic wr,
                              input logic wh, input logic [AW-1:0] dir, input logic [DW-1:0] di,
                              input logic [DW-1:0] do1, input logic [DW-1:0] do2,
                              input logic [CW-1:0] cnt);
    exp_t e;
    e.stall = st; e.busy = bz; e.rd = rd; e.wr = wr; e.wh = wh; e.dir = dir; e.di = di;
    e.do1 = do1; e.do2 = do2; e.cnt = cnt;
    return e;
  endfunction

  // One cycle of stimulus: drive just after the rising edge, queue expectation.
  task automatic step(input lane_t l1, input lane_t l2, input logic rst, input exp_t e,
                      input bit do_care, input string nm);
    @(posedge reloj);
    #1;
    reset        = rst;
    u_if.MEM_RD1 = l1.rd; u_if.MEM_WR1 = l1.wr; u_if.w_h1 = l1.wh;
    u_if.DIR1    = l1.dir; u_if.DI1 = l1.di;
    u_if.MEM_RD2 = l2.rd; u_if.MEM_WR2 = l2.wr; u_if.w_h2 = l2.wh;
    u_if.DIR2    = l2.dir; u_if.DI2 = l2.di;
    exp_q.push_back(e);
    care_q.push_back(do_care);
    name_q.push_back(nm);
    pushed++;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t  e;
    exp_t  a;
    bit    c;
    string nm;
    forever begin
      @(negedge reloj);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        c  = care_q.pop_front();
        nm = name_q.pop_front();
        popped++;
        a = ex(u_if.stall, u_if.busy, u_if.MEM_RD, u_if.MEM_WR, u_if.w_h, u_if.DIR, u_if.DI,
               u_if.DO1, u_if.DO2, u_if.conf_cnt);
        if (!c) begin
          a.do1 = e.do1;
          a.do2 = e.do2;
        end
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got stall=%0b busy=%0b rd=%0b wr=%0b wh=%0b dir=%h di=%h do1=%h do2=%h cnt=%0d | want stall=%0b busy=%0b rd=%0b wr=%0b wh=%0b dir=%h di=%h do1=%h do2=%h cnt=%0d",
                   nm, a.stall, a.busy, a.rd, a.wr, a.wh, a.dir, a.di, a.do1, a.do2, a.cnt,
                   e.stall, e.busy, e.rd, e.wr, e.wh, e.dir, e.di, e.do1, e.do2, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] ecnt;
    u_if.MEM_RD1 = 1'b0; u_if.MEM_WR1 = 1'b0; u_if.w_h1 = 1'b0; u_if.DIR1 = '0; u_if.DI1 = '0;
    u_if.MEM_RD2 = 1'b0; u_if.MEM_WR2 = 1'b0; u_if.w_h2 = 1'b0; u_if.DIR2 = '0; u_if.DI2 = '0;

    step(ln_rd(7'h10, 1'b1), ln_none(), 1'b1, ex(0,0,0,0,0,7'h00,0,0,0,0), 1, "reset_outputs");
    step(ln_rd(7'h10, 1'b1), ln_none(), 1'b0,
         ex(0,0,1,0,1,7'h10,0,32'hDEADBEEF,0,0), 1, "lane1_read");
    step(ln_none(), ln_wr(7'h20, 32'h12345678), 1'b0,
         ex(0,0,0,1,1,7'h20,32'h12345678,0,0,0), 1, "lane2_write");
    step(ln_rd(7'h20, 1'b1), ln_none(), 1'b0,
         ex(0,0,1,0,1,7'h20,0,32'h12345678,0,0), 1, "readback_0x20");
    step(ln_none(), ln_none(), 1'b0, ex(0,0,0,0,0,7'h00,0,0,0,0), 1, "idle");

    step(ln_rd(7'h04, 1'b1), ln_rd(7'h08, 1'b1), 1'b0,
         ex(1,0,1,0,1,7'h04,0,0,0,0), 0, "rr_conflict_c0");
    step(ln_rd(7'h04, 1'b1), ln_rd(7'h08, 1'b1), 1'b0,
         ex(0,1,1,0,1,7'h08,0,32'hA,32'hB,1), 1, "rr_conflict_c1");

    step(ln_wr(7'h0C, 32'h55), ln_rd(7'h0C, 1'b1), 1'b0,
         ex(1,0,0,1,1,7'h0C,32'h55,0,0,1), 0, "wr_rd_c0");
    step(ln_wr(7'h0C, 32'h55), ln_rd(7'h0C, 1'b1), 1'b0,
         ex(0,1,1,0,1,7'h0C,0,0,32'h55,2), 1, "wr_rd_c1");

    begin
      lane_t l = ln_wr(7'h24, 32'h77);
      l.rd = 1'b1;
      step(l, ln_none(), 1'b0, ex(0,0,0,1,1,7'h24,32'h77,0,0,2), 1, "rd_wr_is_write");
    end
    step(ln_none(), ln_rd(7'h24, 1'b1), 1'b0,
         ex(0,0,1,0,1,7'h24,0,0,32'h77,2), 1, "readback_0x24");

    step(ln_rd(7'h10, 1'b1), ln_wr(7'h30, 32'h99), 1'b0,
         ex(1,0,1,0,1,7'h10,0,0,0,2), 0, "rst_second_c0");
    step(ln_rd(7'h10, 1'b1), ln_wr(7'h30, 32'h99), 1'b1,
         ex(0,0,0,0,0,7'h00,0,0,0,0), 1, "rst_second_c1");
    step(ln_rd(7'h30, 1'b1), ln_none(), 1'b0,
         ex(0,0,1,0,1,7'h30,0,32'h11111111,0,0), 1, "no_write_after_rst");

    step(ln_wr(7'h28, 32'hAA), ln_wr(7'h28, 32'hBB), 1'b0,
         ex(1,0,0,1,1,7'h28,32'hAA,0,0,0), 0, "ww_c0");
    step(ln_wr(7'h28, 32'hAA), ln_wr(7'h28, 32'hBB), 1'b0,
         ex(0,1,0,1,1,7'h28,32'hBB,0,32'hAA,1), 1, "ww_c1");
    step(ln_none(), ln_rd(7'h28, 1'b1), 1'b0,
         ex(0,0,1,0,1,7'h28,0,0,32'hBB,1), 1, "ww_lane2_wins");

    step(ln_rd(7'h10, 1'b0), ln_none(), 1'b0,
         ex(0,0,1,0,0,7'h10,0,32'h0000BEEF,0,1), 1, "halfword_read");

    ecnt = 4'd1;
    for (int i = 0; i < 20; i++) begin
      step(ln_rd(7'h04, 1'b1), ln_rd(7'h08, 1'b1), 1'b0,
           ex(1,0,1,0,1,7'h04,0,0,0,ecnt), 0, "sat_c0");
      ecnt = (ecnt == 4'hF) ? 4'hF : ecnt + 4'd1;
      step(ln_rd(7'h04, 1'b1), ln_rd(7'h08, 1'b1), 1'b0,
           ex(0,1,1,0,1,7'h08,0,32'hA,32'hB,ecnt), 1, "sat_c1");
    end
    step(ln_none(), ln_none(), 1'b0, ex(0,0,0,0,0,7'h00,0,0,0,4'hF), 1, "sat_hold");

    repeat (3) @(posedge reloj);
    checks++;
    if (popped != pushed) begin
      failures++;
      $display("FAIL scoreboard_drain: got popped=%0d, want %0d", popped, pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
